// File: rtl/lift_call_scheduler.sv
// Lift call latching and sweep scheduler: IDLE/UP/DOWN/SERVE/EMERG.
// Define LIFT_CALL_EDGE_EN for rising-edge call capture (default: level-sensitive).
module lift_call_scheduler (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] floor_call_buttons,
    input  logic [3:0]  elevator_position_sensor,
    input  logic        door_open_sensor,
    input  logic        fire_alarm_sensor,
    output logic [3:0]  target_floor,
    output logic        target_valid,
    output logic        dir_up,
    output logic [11:0] pending_calls,
    output logic        served
);
    typedef enum logic [2:0] {IDLE, UP, DOWN, SERVE, EMERG} state_t;

    state_t      state;
    logic [3:0]  pos;
    logic        pos_ok;
    logic        clr_en;
    logic [11:0] clr_mask;
    logic [11:0] new_calls;
    logic [11:0] next_pending;
    logic [3:0]  up_floor;
    logic [3:0]  down_floor;
    logic        any_above;
    logic        any_below;
    logic        here;
    logic        tgt_pending;

    assign pos    = elevator_position_sensor;
    assign pos_ok = (pos < 4'd12);
    assign clr_en = (state == SERVE) && door_open_sensor && pos_ok
                    && !fire_alarm_sensor;

    always_comb begin
        up_floor    = 4'd0;
        down_floor  = 4'd0;
        any_above   = 1'b0;
        any_below   = 1'b0;
        here        = 1'b0;
        tgt_pending = 1'b0;
        clr_mask    = '0;
        for (int i = 11; i >= 0; i--) begin
            if (pending_calls[i] && 4'(i) > pos) begin
                up_floor  = 4'(i);
                any_above = 1'b1;
            end
        end
        for (int i = 0; i < 12; i++) begin
            if (pending_calls[i] && 4'(i) < pos) begin
                down_floor = 4'(i);
                any_below  = 1'b1;
            end
            if (pending_calls[i] && 4'(i) == pos)
                here = 1'b1;
            if (pending_calls[i] && 4'(i) == target_floor)
                tgt_pending = 1'b1;
            clr_mask[i] = clr_en && (4'(i) == target_floor);
        end
    end

`ifdef LIFT_CALL_EDGE_EN
    logic [11:0] buttons_q;

    // loaded during reset too, so a button held through reset is not an edge
    always_ff @(posedge clk) begin
        buttons_q <= floor_call_buttons;
    end

    assign new_calls = floor_call_buttons & ~buttons_q;
`else
    // a held button drops on its service cycle and re-latches on the next
    assign new_calls = floor_call_buttons & ~clr_mask;
`endif

    assign next_pending = (pending_calls & ~clr_mask) | new_calls;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pending_calls <= '0;
            target_floor  <= 4'd0;
            target_valid  <= 1'b0;
            dir_up        <= 1'b1;
            served        <= 1'b0;
        end else begin
            served <= 1'b0;
            if (fire_alarm_sensor) begin
                state         <= EMERG;
                pending_calls <= '0;
                target_floor  <= 4'd0;
                target_valid  <= 1'b1;
                dir_up        <= 1'b0;
            end else if (state == EMERG) begin
                state         <= IDLE;
                pending_calls <= '0;
                target_valid  <= 1'b0;
            end else begin
                pending_calls <= next_pending;
                if (pos_ok) begin
                    case (state)
                        IDLE: begin
                            if (here) begin
                                state        <= SERVE;
                                target_floor <= pos;
                                target_valid <= 1'b1;
                            end else if (any_above) begin
                                state        <= UP;
                                target_floor <= up_floor;
                                target_valid <= 1'b1;
                                dir_up       <= 1'b1;
                            end else if (any_below) begin
                                state        <= DOWN;
                                target_floor <= down_floor;
                                target_valid <= 1'b1;
                                dir_up       <= 1'b0;
                            end else begin
                                target_valid <= 1'b0;
                            end
                        end
                        UP, DOWN: begin
                            // a just-served target is stale; only a live call stops us
                            if (pos == target_floor && tgt_pending) begin
                                state <= SERVE;
                            end else if (state == UP ? any_above : !any_below && any_above) begin
                                state        <= UP;
                                target_floor <= up_floor;
                                dir_up       <= 1'b1;
                            end else if (any_below) begin
                                state        <= DOWN;
                                target_floor <= down_floor;
                                dir_up       <= 1'b0;
                            end else begin
                                state        <= IDLE;
                                target_valid <= 1'b0;
                            end
                        end
                        SERVE: begin
                            if (door_open_sensor) begin
                                served <= 1'b1;
                                state  <= dir_up ? UP : DOWN;
                            end
                        end
                        default: begin
                            state        <= IDLE;
                            target_valid <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_lift_call_scheduler.sv
// Scoreboard bench for lift_call_scheduler: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_lift_call_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] btn;
    logic [3:0]  pos;
    logic        door;
    logic        fire;
    logic [3:0]  target_floor;
    logic        target_valid;
    logic        dir_up;
    logic [11:0] pending_calls;
    logic        served;

    lift_call_scheduler dut (
        .clk                      (clk),
        .reset                    (reset),
        .floor_call_buttons       (btn),
        .elevator_position_sensor (pos),
        .door_open_sensor         (door),
        .fire_alarm_sensor        (fire),
        .target_floor             (target_floor),
        .target_valid             (target_valid),
        .dir_up                   (dir_up),
        .pending_calls            (pending_calls),
        .served                   (served)
    );

    always #5 clk = ~clk;

    // care bits: [4]=target_floor [3]=target_valid [2]=dir_up [1]=pending [0]=served
    typedef struct {
        string       name;
        logic [4:0]  care;
        logic [3:0]  tf;
        logic        tv;
        logic        du;
        logic [11:0] pc;
        logic        sv;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;
    bit   ok;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [4:0] care,
                              input logic [3:0] tf, input logic tv,
                              input logic du, input logic [11:0] pc,
                              input logic sv);
        exp_t e;
        e.name = name;
        e.care = care;
        e.tf   = tf;
        e.tv   = tv;
        e.du   = du;
        e.pc   = pc;
        e.sv   = sv;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            checks++;
            ok = 1'b1;
            if (me.care[4] && target_floor !== me.tf) ok = 1'b0;
            if (me.care[3] && target_valid !== me.tv) ok = 1'b0;
            if (me.care[2] && dir_up !== me.du) ok = 1'b0;
            if (me.care[1] && pending_calls !== me.pc) ok = 1'b0;
            if (me.care[0] && served !== me.sv) ok = 1'b0;
            if (!ok) begin
                errors++;
                $display("FAIL %s: got tf=%0d tv=%0b du=%0b pc=%03h sv=%0b want tf=%0d tv=%0b du=%0b pc=%03h sv=%0b care=%05b",
                         me.name, target_floor, target_valid, dir_up,
                         pending_calls, served, me.tf, me.tv, me.du,
                         me.pc, me.sv, me.care);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        btn   = '0;
        pos   = 4'd0;
        door  = 1'b0;
        fire  = 1'b0;
        cyc();
        cyc();
        expect_out("reset", 5'b11111, 4'd0, 1'b0, 1'b1, 12'h000, 1'b0);
        reset = 1'b0;

        // single call at 5 from floor 0, then service
        btn = 12'h020;
        cyc();
        expect_out("latch5", 5'b01011, 4'd0, 1'b0, 1'b0, 12'h020, 1'b0);
        btn = '0;
        cyc();
        expect_out("target5", 5'b11111, 4'd5, 1'b1, 1'b1, 12'h020, 1'b0);
        pos = 4'd5;
        cyc();
        expect_out("serve5", 5'b11011, 4'd5, 1'b1, 1'b0, 12'h020, 1'b0);
        door = 1'b1;
        cyc();
        expect_out("served5", 5'b00011, 4'd0, 1'b0, 1'b0, 12'h000, 1'b1);
        door = 1'b0;
        cyc();
        expect_out("idle5", 5'b01011, 4'd0, 1'b0, 1'b0, 12'h000, 1'b0);

        // sweep: up to 7, 9 then down to 1
        pos = 4'd3;
        btn = 12'h080;
        cyc();
        btn = '0;
        cyc();
        expect_out("up7", 5'b11111, 4'd7, 1'b1, 1'b1, 12'h080, 1'b0);
        btn = 12'h202;
        cyc();
        expect_out("hold7", 5'b11110, 4'd7, 1'b1, 1'b1, 12'h282, 1'b0);
        btn = '0;
        pos = 4'd7;
        cyc();
        expect_out("serve7", 5'b11011, 4'd7, 1'b1, 1'b0, 12'h282, 1'b0);
        door = 1'b1;
        cyc();
        expect_out("served7", 5'b00111, 4'd0, 1'b0, 1'b1, 12'h202, 1'b1);
        door = 1'b0;
        cyc();
        expect_out("up9", 5'b11111, 4'd9, 1'b1, 1'b1, 12'h202, 1'b0);
        pos = 4'd9;
        cyc();
        door = 1'b1;
        cyc();
        expect_out("served9", 5'b00011, 4'd0, 1'b0, 1'b0, 12'h002, 1'b1);
        door = 1'b0;
        cyc();
        expect_out("down1", 5'b11111, 4'd1, 1'b1, 1'b0, 12'h002, 1'b0);
        pos = 4'd1;
        cyc();
        door = 1'b1;
        cyc();
        expect_out("served1", 5'b00011, 4'd0, 1'b0, 1'b0, 12'h000, 1'b1);
        door = 1'b0;
        cyc();
        expect_out("idle1", 5'b01011, 4'd0, 1'b0, 1'b0, 12'h000, 1'b0);

        // fire recall with {4,8} pending
        btn = 12'h110;
        cyc();
        btn = '0;
        cyc();
        expect_out("pend48", 5'b11010, 4'd4, 1'b1, 1'b0, 12'h110, 1'b0);
        fire = 1'b1;
        cyc();
        expect_out("emerg", 5'b11111, 4'd0, 1'b1, 1'b0, 12'h000, 1'b0);
        btn = 12'h004;
        cyc();
        expect_out("emerg_ignore", 5'b11111, 4'd0, 1'b1, 1'b0, 12'h000, 1'b0);
        btn  = '0;
        fire = 1'b0;
        cyc();
        expect_out("emerg_exit", 5'b01011, 4'd0, 1'b0, 1'b0, 12'h000, 1'b0);

        // invalid position freezes scheduling but still latches calls
        pos = 4'd14;
        btn = 12'h004;
        cyc();
        expect_out("frozen_latch", 5'b01011, 4'd0, 1'b0, 1'b0, 12'h004, 1'b0);
        btn = '0;
        cyc();
        expect_out("frozen_hold", 5'b01011, 4'd0, 1'b0, 1'b0, 12'h004, 1'b0);
        pos = 4'd10;
        cyc();
        expect_out("down2", 5'b11111, 4'd2, 1'b1, 1'b0, 12'h004, 1'b0);
        pos = 4'd2;
        cyc();
        expect_out("serve2", 5'b11011, 4'd2, 1'b1, 1'b0, 12'h004, 1'b0);

        // reset beats fire and aborts the service
        door  = 1'b1;
        fire  = 1'b1;
        reset = 1'b1;
        cyc();
        expect_out("reset_abort", 5'b11111, 4'd0, 1'b0, 1'b1, 12'h000, 1'b0);
        door  = 1'b0;
        fire  = 1'b0;
        reset = 1'b0;

`ifdef LIFT_CALL_EDGE_EN
        btn   = 12'h008;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        expect_out("held_reset", 5'b01011, 4'd0, 1'b0, 1'b0, 12'h000, 1'b0);
        btn = '0;
        cyc();
        pos = 4'd6;
        btn = 12'h040;
        cyc();
        btn = '0;
        cyc();
        expect_out("serve6", 5'b11011, 4'd6, 1'b1, 1'b0, 12'h040, 1'b0);
        door = 1'b1;
        btn  = 12'h040;
        cyc();
        expect_out("served6_set", 5'b00011, 4'd0, 1'b0, 1'b0, 12'h040, 1'b1);
        door = 1'b0;
        btn  = '0;
        cyc();
        cyc();
        expect_out("reserve6", 5'b11011, 4'd6, 1'b1, 1'b0, 12'h040, 1'b0);
`else
        pos = 4'd3;
        btn = 12'h008;
        cyc();
        cyc();
        expect_out("serve3", 5'b11011, 4'd3, 1'b1, 1'b0, 12'h008, 1'b0);
        door = 1'b1;
        cyc();
        expect_out("served3", 5'b00011, 4'd0, 1'b0, 1'b0, 12'h000, 1'b1);
        door = 1'b0;
        cyc();
        expect_out("relatch3", 5'b01011, 4'd0, 1'b0, 1'b0, 12'h008, 1'b0);
        btn = '0;
        cyc();
        expect_out("reserve3", 5'b11011, 4'd3, 1'b1, 1'b0, 12'h008, 1'b0);
`endif

        for (int k = 0; k < 10 && sb.size() > 0; k++)
            @(negedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lift_call_scheduler.md
LIFT_CALL_SCHEDULER -- requirements
Module: lift_call_scheduler

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-002 SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have the port floor_call_buttons, input, 12 bits: raw call buttons; bit n = floor n.
REQ-004 SHALL have the port elevator_position_sensor, input, 4 bits: current floor, 0-11 valid; 12-15 invalid.
REQ-005 SHALL have the port door_open_sensor, input, 1 bit: door fully open at current floor.
REQ-006 SHALL have the port fire_alarm_sensor, input, 1 bit: emergency recall request.
REQ-007 SHALL have the port target_floor, output, 4 bits: next floor for the lift FSM.
REQ-008 SHALL have the port target_valid, output, 1 bit: target_floor is meaningful.
REQ-009 SHALL have the port dir_up, output, 1 bit: 1 = sweeping up, 0 = sweeping down.
REQ-010 SHALL have the port pending_calls, output, 12 bits: latched unserved calls.
REQ-011 SHALL have the port served, output, 1 bit: one-cycle pulse when a call is cleared.

Function
REQ-012 SHALL, with LIFT_CALL_EDGE_EN defined, set pending bit n on the cycle after a 0->1 edge of floor_call_buttons[n].
REQ-013 SHALL give a set event priority over a clear event for the same bit in the same cycle, so the bit remains pending.
REQ-014 SHALL implement the FSM states IDLE, UP, DOWN, SERVE and EMERG, all registered; every output SHALL be registered.
REQ-015 SHALL, in IDLE, take these transitions in priority order:
- pending[pos] set -> SERVE, target = pos;
- any pending above pos -> UP;
- any pending below pos -> DOWN;
- otherwise stay in IDLE with target_valid=0.
REQ-016 SHALL, in UP, set target to the lowest pending floor > pos with dir_up=1.
- None above and some below -> DOWN.
- None at all -> IDLE.
REQ-017 SHALL, in DOWN, set target to the highest pending floor < pos with dir_up=0.
- None below and some above -> UP.
- None at all -> IDLE.
REQ-018 SHALL, in UP or DOWN, go to SERVE when pos == target_floor.
REQ-019 SHALL, in SERVE with door_open_sensor=1, perform the following in the same cycle:
- clear pending[target];
- pulse served for exactly 1 cycle;
- go to UP if dir_up=1, else DOWN.
REQ-020 SHALL, in SERVE with door_open_sensor=0, hold target and state.
REQ-021 SHALL go to EMERG from any state when fire_alarm_sensor=1, with priority over all other transitions.
REQ-022 SHALL, in EMERG:
- clear pending_calls to 0;
- ignore buttons;
- drive target_floor=0, target_valid=1, dir_up=0;
- go to IDLE on the cycle after fire_alarm_sensor falls.
REQ-023 SHALL, when pos >= 12, hold state, target and pending unchanged while still accepting new calls.
REQ-024 SHALL take 2 cycles from a button edge to a target_floor/target_valid update: 1 cycle to latch, 1 cycle to schedule.
REQ-025 SHALL hold target_valid=1 in UP, DOWN, SERVE and EMERG, and 0 in IDLE.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, set state=IDLE, pending_calls=0, target_floor=0, target_valid=0, dir_up=1 and served=0.
REQ-027 SHALL give reset priority over fire_alarm_sensor, abort any SERVE in progress, and leave served low.
REQ-028 SHALL, on the cycle after reset, sample the buttons as the edge-detector baseline, so a button already held through reset does not register.

Configuration
REQ-029 SHALL, with LIFT_CALL_EDGE_EN defined, register only rising edges via an internal 12-bit previous-button register.
REQ-030 SHALL, with LIFT_CALL_EDGE_EN undefined:
- make calls level-sensitive, OR-ing floor_call_buttons into pending every cycle;
- re-register a button still held after SERVE on the next cycle;
- omit the previous-button register.

Verification
REQ-031 SHALL cover: pos=0, pulse button[5] -> 2 cycles later target_floor=5, target_valid=1, dir_up=1; pos=5 plus door_open -> served pulse, pending_calls=0, IDLE.
REQ-032 SHALL cover: pos=3, calls at 7, 9 and 1 while in UP -> targets 7, 9, then DOWN with target 1 after 7 and 9 are served.
REQ-033 SHALL cover: pending {4,8}, fire_alarm=1 -> next cycle pending_calls=0 and target_floor=0; alarm low -> IDLE and target_valid=0.
REQ-034 SHALL cover: in SERVE at floor 6, a button[6] edge in the same cycle as door_open -> served=1 and pending[6] still 1.
REQ-035 SHALL cover: pos=14, call at 2 -> pending[2]=1 while state and target stay frozen; pos=10 -> DOWN with target 2.
REQ-036 SHALL cover: with the macro undefined, button[3] held through its service -> pending[3] set again 1 cycle after served.
